sata_dev_link_supervisor: RTL and testbench

Sequencing controller for the device-side SATA OOB unit. It holds the OOB unit in reset until the transceiver is ready and then releases it. It services the OOB unit's TX PCS reset request with a timed GTX `txpcsreset` pulse and a `recal_tx_done` handshake, and watches `link_up`. On timeout or link loss it restarts the OOB sequence, and it declares permanent failure after a bounded number of retries.

---
 rtl/sata_dev_pkg.sv | 34 +++
 rtl/sata_edge_det.sv | 27 ++
 rtl/sata_dev_link_supervisor.sv | 120 ++++++++++++
 tb/tb_sata_dev_link_supervisor.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_dev_pkg.sv
// Shared definitions for the device-side SATA link bring-up logic:
// supervisor state encoding, counter widths and default wait intervals
// (also used by oob_dev for its retry and wait intervals).
package sata_dev_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_PCSRST  = 3'd3,
    ST_PCSWAIT = 3'd4,
    ST_LINK    = 3'd5,
    ST_HOLDOFF = 3'd6,
    ST_FAIL    = 3'd7
  } sup_state_t;

  localparam int TIMER_W = 20;
  localparam int RETRY_W = 4;

  // OOB unit is held in reset this long after the transceiver reports ready
  localparam int HOLD_CYCLES = 4;

  localparam int DEF_PCSRESET_CYCLES   = 8;
  localparam int DEF_RESETDONE_TIMEOUT = 1024;
  localparam int DEF_LINKUP_TIMEOUT    = 65535;
  localparam int DEF_HOLDOFF_CYCLES    = 256;
  localparam int DEF_MAX_RETRIES       = 7;

  // Retry counter increment, sticking at all-ones
  function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/sata_edge_det.sv
// Registered rising-edge detector. 'preset' loads the history register
// with 1 so a level that is already high is not reported as an edge.
module sata_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic preset,
  input  logic d,
  output logic rise
);

  logic prev;

  // History register and registered edge pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b1;
      rise <= 1'b0;
    end else if (preset) begin
      prev <= 1'b1;
      rise <= 1'b0;
    end else begin
      prev <= d;
      rise <= d & ~prev;
    end
  end

endmodule

// File: rtl/sata_dev_link_supervisor.sv
// Device-side SATA link supervisor: holds the OOB unit in reset until the
// GTX is ready, services TX PCS reset requests, watches link_up and
// restarts the OOB sequence on timeout or link loss, giving up after a
// bounded number of failed attempts.
module sata_dev_link_supervisor
  import sata_dev_pkg::*;
#(
  parameter int PCSRESET_CYCLES   = DEF_PCSRESET_CYCLES,
  parameter int RESETDONE_TIMEOUT = DEF_RESETDONE_TIMEOUT,
  parameter int LINKUP_TIMEOUT    = DEF_LINKUP_TIMEOUT,
  parameter int HOLDOFF_CYCLES    = DEF_HOLDOFF_CYCLES,
  parameter int MAX_RETRIES       = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       gtx_ready,
  output logic       oob_rst,
  input  logic       txpcsreset_req,
  output logic       txpcsreset,
  input  logic       txresetdone,
  output logic       recal_tx_done,
  input  logic       link_up,
  output logic       link_ok,
  output logic       link_fail,
  output logic [3:0] retry_cnt
);

  // Terminal timer values; the timer reads 0 in the first cycle of a state
  localparam logic [TIMER_W-1:0] T_HOLD_END = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_PCS_END  = TIMER_W'(PCSRESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_DONE_TO  = TIMER_W'(RESETDONE_TIMEOUT);
  localparam logic [TIMER_W-1:0] T_LINK_TO  = TIMER_W'(LINKUP_TIMEOUT);
  localparam logic [TIMER_W-1:0] T_HOFF_END = TIMER_W'(HOLDOFF_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRIES);

  sup_state_t           state, state_n;
  logic [TIMER_W-1:0]   timer;
  logic [RETRY_W-1:0]   retry_inc;
  logic                 retry_ev;
  logic                 pcs_start;
  logic                 done_rise;
  logic                 timed_state;

  assign retry_inc   = retry_sat_inc(retry_cnt);
  assign timed_state = state inside {ST_HOLD, ST_RUN, ST_PCSRST, ST_PCSWAIT, ST_HOLDOFF};
  // Arms the txresetdone history on the cycle the PCS reset begins
  assign pcs_start   = (state == ST_RUN) && (state_n == ST_PCSRST);

  sata_edge_det u_done_edge (
    .clk    (clk),
    .rst    (rst),
    .preset (pcs_start),
    .d      (txresetdone),
    .rise   (done_rise)
  );

  // Next-state and retry-event decode
  always_comb begin
    state_n  = state;
    retry_ev = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (gtx_ready) state_n = ST_HOLD;
        ST_HOLD:    if (timer == T_HOLD_END) state_n = ST_RUN;
        ST_RUN: begin
          if (!gtx_ready)                            retry_ev = 1'b1;
          else if (link_up)                          state_n  = ST_LINK;
          // recal_tx_done high means this is the first RUN cycle after a
          // completed PCS reset; the request level is still up from it
          else if (txpcsreset_req && !recal_tx_done) state_n  = ST_PCSRST;
          else if (timer == T_LINK_TO)               retry_ev = 1'b1;
        end
        // gtx_ready drops while the GTX is resetting its PCS, so it is not
        // checked in the PCS reset states
        ST_PCSRST:  if (timer == T_PCS_END) state_n = ST_PCSWAIT;
        ST_PCSWAIT: begin
          if (done_rise)               state_n  = ST_RUN;
          else if (timer == T_DONE_TO) retry_ev = 1'b1;
        end
        ST_LINK:    if (!link_up || !gtx_ready) retry_ev = 1'b1;
        ST_HOLDOFF: if (timer == T_HOFF_END) state_n = gtx_ready ? ST_RUN : ST_IDLE;
        default:    state_n = state;
      endcase
      if (retry_ev) state_n = (retry_inc == RETRY_LIM) ? ST_FAIL : ST_HOLDOFF;
    end
  end

  // State, timer, retry counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      timer         <= '0;
      retry_cnt     <= '0;
      oob_rst       <= 1'b1;
      txpcsreset    <= 1'b0;
      recal_tx_done <= 1'b0;
      link_ok       <= 1'b0;
      link_fail     <= 1'b0;
    end else begin
      state <= state_n;

      if (state_n != state)  timer <= '0;
      else if (timed_state)  timer <= timer + TIMER_W'(1);

      if (!enable)                                      retry_cnt <= '0;
      else if (state_n == ST_LINK && state != ST_LINK) retry_cnt <= '0;
      else if (retry_ev)                                retry_cnt <= retry_inc;

      oob_rst       <= state_n inside {ST_IDLE, ST_HOLD, ST_HOLDOFF, ST_FAIL};
      txpcsreset    <= (state_n == ST_PCSRST);
      recal_tx_done <= (state == ST_PCSWAIT) && (state_n == ST_RUN);
      link_ok       <= (state_n == ST_LINK);
      link_fail     <= (state_n == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_sata_dev_link_supervisor.sv
// Bench for sata_dev_link_supervisor: reference model compared every cycle,
// a vector table from reset, hand sequences for the timed corner cases and
// a randomized phase.
module tb_sata_dev_link_supervisor;

  localparam int PCS_N   = 8;
  localparam int DONE_TO = 1024;
  localparam int LINK_TO = 300;
  localparam int HOFF_N  = 256;
  localparam int MAXR    = 7;

  logic       clk = 1'b0;
  logic       rst, enable, gtx_ready, txpcsreset_req, txresetdone, link_up;
  logic       oob_rst, txpcsreset, recal_tx_done, link_ok, link_fail;
  logic [3:0] retry_cnt;

  always #5 clk = ~clk;

  sata_dev_link_supervisor #(
    .PCSRESET_CYCLES   (PCS_N),
    .RESETDONE_TIMEOUT (DONE_TO),
    .LINKUP_TIMEOUT    (LINK_TO),
    .HOLDOFF_CYCLES    (HOFF_N),
    .MAX_RETRIES       (MAXR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .gtx_ready      (gtx_ready),
    .oob_rst        (oob_rst),
    .txpcsreset_req (txpcsreset_req),
    .txpcsreset     (txpcsreset),
    .txresetdone    (txresetdone),
    .recal_tx_done  (recal_tx_done),
    .link_up        (link_up),
    .link_ok        (link_ok),
    .link_fail      (link_fail),
    .retry_cnt      (retry_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_HOLD = 1, M_RUN = 2, M_PCSRST = 3,
                 M_PCSWAIT = 4, M_LINK = 5, M_HOLDOFF = 6, M_FAIL = 7;

  int m_st = M_IDLE, m_retry = 0, m_now = 0, m_enter = 0;
  bit m_hist = 1'b1, m_rise = 1'b0, m_recal = 1'b0;

  // Advance the model by one clock using the inputs the DUT is about to sample
  task automatic m_step();
    int nx, age;
    bit ev;
    if (rst) begin
      m_st = M_IDLE; m_retry = 0; m_hist = 1'b1; m_rise = 1'b0; m_recal = 1'b0;
      m_enter = m_now + 1; m_now++;
      return;
    end
    age = m_now - m_enter;
    nx  = m_st;
    ev  = 1'b0;
    if (!enable) nx = M_IDLE;
    else begin
      case (m_st)
        M_IDLE:    if (gtx_ready) nx = M_HOLD;
        M_HOLD:    if (age == 3) nx = M_RUN;
        M_RUN: begin
          if (!gtx_ready)                      ev = 1'b1;
          else if (link_up)                    nx = M_LINK;
          else if (txpcsreset_req && !m_recal) nx = M_PCSRST;
          else if (age == LINK_TO)             ev = 1'b1;
        end
        M_PCSRST:  if (age == PCS_N - 1) nx = M_PCSWAIT;
        M_PCSWAIT: begin
          if (m_rise)              nx = M_RUN;
          else if (age == DONE_TO) ev = 1'b1;
        end
        M_LINK:    if (!link_up || !gtx_ready) ev = 1'b1;
        M_HOLDOFF: if (age == HOFF_N - 1) nx = gtx_ready ? M_RUN : M_IDLE;
        default:   ;
      endcase
    end
    if (ev) begin
      m_retry = (m_retry < 15) ? m_retry + 1 : 15;
      nx = (m_retry == MAXR) ? M_FAIL : M_HOLDOFF;
    end
    if (!enable) m_retry = 0;
    if (nx == M_LINK && m_st != M_LINK) m_retry = 0;
    if (m_st == M_RUN && nx == M_PCSRST) begin
      m_hist = 1'b1; m_rise = 1'b0;
    end else begin
      m_rise = txresetdone && !m_hist; m_hist = txresetdone;
    end
    m_recal = (m_st == M_PCSWAIT) && (nx == M_RUN);
    if (nx != m_st) m_enter = m_now + 1;
    m_st = nx;
    m_now++;
  endtask

  function automatic logic [8:0] m_exp();
    logic o;
    o = (m_st == M_IDLE) || (m_st == M_HOLD) || (m_st == M_HOLDOFF) || (m_st == M_FAIL);
    return {o, m_st == M_PCSRST, m_recal, m_st == M_LINK, m_st == M_FAIL, 4'(m_retry)};
  endfunction

  function automatic logic [8:0] outs();
    return {oob_rst, txpcsreset, recal_tx_done, link_ok, link_fail, retry_cnt};
  endfunction

  // One clock: model step, edge, then compare away from the edge
  task automatic cycle();
    m_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("model", outs(), m_exp());
  endtask

  task automatic do_reset();
    rst = 1; enable = 0; gtx_ready = 0; txpcsreset_req = 0; txresetdone = 0; link_up = 0;
    cycle(); cycle();
    rst = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       r, en, gtx, req, txd, lnk;
    logic [8:0] exp;   // {oob_rst, txpcsreset, recal, link_ok, link_fail, retry_cnt}
  } vec_t;

  function automatic vec_t mk(logic r, logic en, logic g, logic q, logic t, logic l, logic [8:0] x);
    vec_t v;
    v.r = r; v.en = en; v.gtx = g; v.req = q; v.txd = t; v.lnk = l; v.exp = x;
    return v;
  endfunction

  vec_t vt[18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int hi, rises, recals, seen, n, lrate;
    bit pt;

    vt[0]  = mk(1, 0, 0, 0, 0, 0, 9'b1_0000_0000); // reset values
    vt[1]  = mk(0, 1, 1, 0, 0, 0, 9'b1_0000_0000); // HOLD
    vt[2]  = mk(0, 1, 1, 0, 0, 0, 9'b1_0000_0000);
    vt[3]  = mk(0, 1, 1, 0, 0, 0, 9'b1_0000_0000);
    vt[4]  = mk(0, 1, 1, 0, 0, 0, 9'b1_0000_0000);
    vt[5]  = mk(0, 1, 1, 0, 0, 0, 9'b0_0000_0000); // RUN after 4 HOLD cycles
    vt[6]  = mk(0, 1, 1, 0, 0, 1, 9'b0_0010_0000); // LINK
    vt[7]  = mk(0, 1, 1, 0, 0, 1, 9'b0_0010_0000);
    vt[8]  = mk(0, 1, 1, 0, 0, 0, 9'b1_0000_0001); // link loss -> HOLDOFF
    vt[9]  = mk(0, 1, 1, 0, 0, 0, 9'b1_0000_0001);
    vt[10] = mk(0, 0, 1, 0, 0, 0, 9'b1_0000_0000); // disable -> IDLE, cleared
    vt[11] = mk(0, 1, 0, 0, 0, 0, 9'b1_0000_0000); // IDLE waits for gtx_ready
    vt[12] = mk(0, 1, 1, 0, 0, 0, 9'b1_0000_0000); // HOLD
    vt[13] = mk(0, 1, 1, 0, 0, 0, 9'b1_0000_0000);
    vt[14] = mk(0, 1, 1, 0, 0, 0, 9'b1_0000_0000);
    vt[15] = mk(0, 1, 1, 0, 0, 0, 9'b1_0000_0000);
    vt[16] = mk(0, 1, 1, 0, 0, 0, 9'b0_0000_0000); // RUN
    vt[17] = mk(0, 1, 0, 0, 0, 0, 9'b1_0000_0001); // gtx_ready low in RUN -> retry

    rst = 1; enable = 0; gtx_ready = 0; txpcsreset_req = 0; txresetdone = 0; link_up = 0;
    for (int i = 0; i < 18; i++) begin
      rst = vt[i].r; enable = vt[i].en; gtx_ready = vt[i].gtx;
      txpcsreset_req = vt[i].req; txresetdone = vt[i].txd; link_up = vt[i].lnk;
      cycle();
      check($sformatf("vec%0d", i), outs(), vt[i].exp);
    end

    // Normal bring-up with one PCS reset
    do_reset();
    enable = 1; gtx_ready = 1;
    for (int k = 0; k < 20; k++) cycle();
    txpcsreset_req = 1;
    cycle();
    check("A req_to_txp", txpcsreset, 1'b1);
    hi = 1; rises = 1; recals = 0; seen = -1; pt = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      if (k >= 30) txresetdone = 1;
      if (seen >= 0 && k == seen + 2) txpcsreset_req = 0;
      cycle();
      if (txpcsreset) hi++;
      if (txpcsreset && !pt) rises++;
      pt = txpcsreset;
      if (recal_tx_done) begin recals++; if (seen < 0) seen = k; end
    end
    check("A txp_high", hi, PCS_N);
    check("A txp_rises", rises, 1);
    check("A recal_pulses", recals, 1);
    check("A recal_time", seen, 31);
    link_up = 1;
    cycle();
    check("A link_ok", {link_ok, retry_cnt}, 5'b1_0000);

    // Stale txresetdone level never completes the wait
    do_reset();
    enable = 1; gtx_ready = 1; txresetdone = 1; txpcsreset_req = 1;
    for (int k = 0; k < 20 && !txpcsreset; k++) cycle();
    check("B pcs_start", txpcsreset, 1'b1);
    for (int k = 0; k < 20 && txpcsreset; k++) cycle();
    check("B pcs_end", txpcsreset, 1'b0);
    n = 0; recals = 0;
    while (!oob_rst && n < 2000) begin cycle(); n++; if (recal_tx_done) recals++; end
    check("B wait_len", n, DONE_TO + 1);
    check("B no_recal", recals, 0);
    check("B retry", retry_cnt, 1);
    n = 0;
    while (oob_rst && n < 1000) begin n++; cycle(); end
    check("B holdoff_len", n, HOFF_N);

    // No link: retries exhaust into FAIL
    do_reset();
    enable = 1; gtx_ready = 1;
    for (int k = 0; k < 8000 && !link_fail; k++) cycle();
    check("C fail", outs(), 9'b1_0001_0111);
    enable = 0;
    cycle();
    check("C disable", outs(), 9'b1_0000_0000);

    // Link loss and relink
    do_reset();
    enable = 1; gtx_ready = 1;
    for (int k = 0; k < 10; k++) cycle();
    link_up = 1;
    cycle();
    check("D link", link_ok, 1'b1);
    link_up = 0;
    cycle();
    check("D loss", outs(), 9'b1_0000_0001);
    link_up = 1;
    for (int k = 0; k < 400 && !link_ok; k++) cycle();
    check("D relink", {link_ok, retry_cnt}, 5'b1_0000);

    // gtx_ready glitches: ignored during PCS reset, fatal in RUN
    do_reset();
    enable = 1; gtx_ready = 1; txpcsreset_req = 1;
    for (int k = 0; k < 20 && !txpcsreset; k++) cycle();
    gtx_ready = 0;
    for (int k = 0; k < 3; k++) cycle();
    check("E gtx_low_pcsrst", {oob_rst, txpcsreset, retry_cnt}, 6'b01_0000);
    gtx_ready = 1;
    for (int k = 0; k < 20 && txpcsreset; k++) cycle();
    gtx_ready = 0;
    for (int k = 0; k < 5; k++) cycle();
    check("E gtx_low_pcswait", {oob_rst, retry_cnt}, 5'b0_0000);
    gtx_ready = 1; txresetdone = 1;
    for (int k = 0; k < 20 && !recal_tx_done; k++) cycle();
    check("E recal", recal_tx_done, 1'b1);
    gtx_ready = 0;
    cycle();
    check("E gtx_low_run", {oob_rst, retry_cnt}, 5'b1_0001);

    // rst and enable=0 in the middle of a PCS reset
    do_reset();
    enable = 1; gtx_ready = 1; txpcsreset_req = 1;
    for (int k = 0; k < 20 && !txpcsreset; k++) cycle();
    cycle();
    rst = 1;
    cycle();
    check("F rst_pcsrst", outs(), 9'b1_0000_0000);
    rst = 0;
    for (int k = 0; k < 30 && !txpcsreset; k++) cycle();
    check("F pcs_again", txpcsreset, 1'b1);
    enable = 0;
    cycle();
    check("F dis_pcsrst", outs(), 9'b1_0000_0000);

    // Randomized traffic against the model
    do_reset();
    enable = 1; gtx_ready = 1;
    for (int k = 0; k < 8000; k++) begin
      lrate = (k < 4000) ? 40 : 700;
      rst       = ($urandom_range(0, 1999) == 0);
      enable    = ($urandom_range(0, 299) != 0);
      gtx_ready = ($urandom_range(0, 29) != 0);
      if (!txpcsreset_req && $urandom_range(0, 39) == 0) txpcsreset_req = 1;
      else if (txpcsreset_req && $urandom_range(0, 99) == 0) txpcsreset_req = 0;
      if ($urandom_range(0, 15) == 0) txresetdone = ~txresetdone;
      if ($urandom_range(0, lrate - 1) == 0) link_up = ~link_up;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
